// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions for the board serial link.
// Line levels and frame geometry are common to the transmit and receive halves,
// so both sides agree on polarity and data width from a single place.
package uart_transmitter_pkg;

  // Number of data bits carried in one 8N1 frame.
  localparam int UART_DATA_BITS = 8;

  // Width of the index that walks through the data bits of a frame.
  localparam int BIT_INDEX_W = $clog2(UART_DATA_BITS);

  // Line level driven during the start bit.
  localparam logic START_BIT_LEVEL = 1'b0;

  // Line level driven during the stop bit.
  localparam logic STOP_BIT_LEVEL = 1'b1;

  // Line level while nothing is being sent.
  localparam logic IDLE_LEVEL = 1'b1;

  // Clock cycles per bit on the wire; integer division truncates toward
  // zero, so the real baud rate is never slower than requested.
  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Width of a counter that must hold 0..symbol_time-1 with one bit of headroom.
  function automatic int symbol_counter_width(input int symbol_time);
    return $clog2(symbol_time) + 1;
  endfunction

endpackage

// File: rtl/uart_transmitter_baud_counter.sv
// Bit-period timer shared by the UART transmit and receive halves.
// Counts clk cycles within one symbol and emits a single-cycle pulse on the
// last cycle of each symbol. Holding clear keeps it parked at zero, so the
// first symbol after clear is released is always a full period long.
module uart_baud_counter
  import uart_transmitter_pkg::*;
#(
  parameter int SYMBOL_EDGE_TIME = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic symbol_done
);

  localparam int COUNT_W = symbol_counter_width(SYMBOL_EDGE_TIME);
  localparam logic [COUNT_W-1:0] TERMINAL = COUNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [COUNT_W-1:0] STEP = COUNT_W'(1);

  logic [COUNT_W-1:0] count;

  // Free-running symbol counter: wraps at the terminal count, parks at zero while cleared.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == TERMINAL) begin
      count <= '0;
    end else begin
      count <= count + STEP;
    end
  end

  // The pulse is suppressed while cleared so a parked counter never advances the caller.
  assign symbol_done = (count == TERMINAL) && !clear;

endmodule

// File: rtl/uart_transmitter.sv
// Transmit half of the board serial link.
// Accepts bytes from an on-chip producer over ready/valid and serialises them
// as 8N1 frames, LSB first. The TX pin is driven straight from a flip-flop so
// the pad never sees decode glitches; the next line level is computed from the
// next state, so the registered output still changes in the same cycle the
// state does.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam logic [BIT_INDEX_W-1:0] LAST_BIT = BIT_INDEX_W'(UART_DATA_BITS - 1);
  localparam logic [BIT_INDEX_W-1:0] INDEX_STEP = BIT_INDEX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  tx_state_t state;
  tx_state_t next_state;

  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [UART_DATA_BITS-1:0] shift_next;
  logic [BIT_INDEX_W-1:0]    bit_index;
  logic [BIT_INDEX_W-1:0]    bit_index_next;
  logic                      line_next;
  logic                      counter_clear;
  logic                      symbol_done;
  logic                      accept;

  // A byte changes hands only when the producer offers it and we are idle.
  assign accept = data_in_valid && data_in_ready;

  // The counter is held at zero all through IDLE, which clears it on entry to START.
  uart_baud_counter #(
    .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
  ) u_baud_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (counter_clear),
    .symbol_done(symbol_done)
  );

  // State register; reset drops any frame in flight and returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Frame sequencing: every transition out of a bit happens on the symbol-done pulse.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = START;
        end
      end
      START: begin
        if (symbol_done) begin
          next_state = DATA;
        end
      end
      DATA: begin
        if (symbol_done && (bit_index == LAST_BIT)) begin
          next_state = STOP;
        end
      end
      STOP: begin
        if (symbol_done) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode: handshake, counter control, and the level the line takes next cycle.
  always_comb begin
    data_in_ready  = (state == IDLE);
    counter_clear  = (state == IDLE);
    shift_next     = shift_reg;
    bit_index_next = bit_index;
    line_next      = IDLE_LEVEL;

    if (accept) begin
      shift_next     = data_in;
      bit_index_next = '0;
    end else if ((state == DATA) && symbol_done) begin
      shift_next     = shift_reg >> 1;
      bit_index_next = bit_index + INDEX_STEP;
    end

    case (next_state)
      IDLE:    line_next = IDLE_LEVEL;
      START:   line_next = START_BIT_LEVEL;
      DATA:    line_next = shift_next[0];
      STOP:    line_next = STOP_BIT_LEVEL;
      default: line_next = IDLE_LEVEL;
    endcase
  end

  // Datapath registers, including the flop that drives the TX pin directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg  <= '0;
      bit_index  <= '0;
      serial_out <= IDLE_LEVEL;
    end else begin
      shift_reg  <= shift_next;
      bit_index  <= bit_index_next;
      serial_out <= line_next;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter at CLOCK_FREQ=1000, BAUD_RATE=100 (10 cycles per bit).
// Stimulus pushes each accepted byte into a queue; an independent line monitor
// decodes frames from serial_out and pops the queue to compare.
module tb_uart_transmitter;

  localparam int CLOCK_FREQ = 1000;
  localparam int BAUD_RATE  = 100;
  localparam int BIT_CYCLES = 10;
  localparam int FRAME_CYCLES = 10 * BIT_CYCLES;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  uart_transmitter #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Waits (from a negedge) until the DUT is ready, with a bounded budget.
  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (data_in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  // Offers one byte for a single cycle; returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] b);
    bit ok;
    @(negedge clk);
    waitReady(ok);
    if (ok) begin
      data_in = b;
      data_in_valid = 1'b1;
      exp_q.push_back(b);
      @(posedge clk);
      #1;
      data_in_valid = 1'b0;
    end
  endtask

  // Waits until every expected frame has been seen and the line is back idle.
  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && data_in_ready === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drain_timeout", {31'd0, done}, 32'd1);
    repeat (5) @(negedge clk);
  endtask

  // Line monitor: detects a start bit, samples each bit mid-symbol, checks framing and data.
  initial begin : line_monitor
    logic [9:0] bits;
    logic [7:0] expected;
    bit aborted;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && serial_out === 1'b0) begin
        bits = '0;
        aborted = 1'b0;
        for (int c = 1; c <= 94; c++) begin
          @(negedge clk);
          if (reset !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (c % BIT_CYCLES == 4) bits[c / BIT_CYCLES] = serial_out;
        end
        if (!aborted) begin
          checkOutput("frame_start_bit", {31'd0, bits[0]}, 32'd0);
          checkOutput("frame_stop_bit", {31'd0, bits[9]}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_frame actual=%0h expected=none", bits[8:1]);
          end else begin
            expected = exp_q.pop_front();
            checkOutput("frame_data", {24'd0, bits[8:1]}, {24'd0, expected});
          end
        end
      end
    end
  end

  // Hard stop in case something outside the bounded waits stalls.
  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int cnt;
    int gap;
    logic prev;
    bit found;

    // Reset held three cycles, then the line must sit idle and ready.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("idle_ready", {31'd0, data_in_ready}, 32'd1);
      checkOutput("idle_line", {31'd0, serial_out}, 32'd1);
    end

    // Reset and valid together: reset wins and nothing is accepted.
    @(posedge clk);
    #1;
    reset = 1'b1;
    data_in = 8'h55;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    data_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("reset_valid_no_accept", {30'd0, data_in_ready, serial_out}, 32'd3);
    end

    // 0xA5 with a one-cycle valid: start falls next cycle, ready low for one frame.
    applyStimulus(8'hA5);
    cnt = 0;
    @(negedge clk);
    checkOutput("start_latency", {31'd0, serial_out}, 32'd0);
    while (data_in_ready === 1'b0 && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("ready_low_cycles", cnt, FRAME_CYCLES);
    checkOutput("line_idle_after_frame", {31'd0, serial_out}, 32'd1);
    waitDrain();

    // Valid held across 0x00 then 0xFF: second start 100 or 101 cycles after the first.
    @(negedge clk);
    data_in = 8'h00;
    data_in_valid = 1'b1;
    exp_q.push_back(8'h00);
    @(posedge clk);
    #1;
    data_in = 8'hFF;
    exp_q.push_back(8'hFF);
    @(negedge clk);
    checkOutput("b2b_first_start", {31'd0, serial_out}, 32'd0);
    prev = serial_out;
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cnt++;
      if (prev === 1'b1 && serial_out === 1'b0) begin
        found = 1'b1;
        break;
      end
      prev = serial_out;
    end
    data_in_valid = 1'b0;
    checkOutput("b2b_second_start_seen", {31'd0, found}, 32'd1);
    checkOutput("b2b_start_spacing_ok", {31'd0, (cnt == 100 || cnt == 101)}, 32'd1);
    waitDrain();

    // 0x3C accepted, then data changes and valid pulses mid-frame: no effect.
    applyStimulus(8'h3C);
    repeat (24) @(posedge clk);
    #1;
    data_in = 8'hFF;
    data_in_valid = 1'b1;
    @(negedge clk);
    checkOutput("busy_not_ready", {31'd0, data_in_ready}, 32'd0);
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    waitDrain();
    repeat (150) @(negedge clk);

    // Reset 35 cycles into a 0x5A frame, then a clean 0x81 frame.
    applyStimulus(8'h5A);
    repeat (35) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midframe_reset_line", {31'd0, serial_out}, 32'd1);
    checkOutput("midframe_reset_ready", {31'd0, data_in_ready}, 32'd1);
    applyStimulus(8'h81);
    waitDrain();

    // Stream of random bytes with random idle gaps.
    for (int n = 0; n < 24; n++) begin
      gap = $urandom_range(0, 12);
      repeat (gap) @(posedge clk);
      applyStimulus(8'($urandom_range(0, 255)));
    end
    waitDrain();
    checkOutput("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
